ds_pwm_stage: RTL and testbench

- Output stage directly downstream of delta_sigma_modulator. Consumes its multi-bit quantized sample y / y_valid and converts each sample into one PWM frame on a single-bit pin.
- Double-buffered: a pending register absorbs asynchronous sample arrival; the duty register is loaded only at frame boundaries.
- Flags overrun/underrun and emits a sample_req pulse that can pace the modulator.

---
 rtl/ds_dac_pkg.sv | 21 ++
 rtl/pwm_compare.sv | 36 +++
 rtl/ds_pwm_stage.sv | 115 +++++++++++
 tb/tb_ds_pwm_stage.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ds_dac_pkg.sv
// Shared types and helpers for the delta-sigma DAC output path.
// Holds the default sample width, the PWM alignment mode and the input code conversion.
package ds_dac_pkg;

   localparam int DEFAULT_OUT_BITS = 9;

   typedef enum logic {
      PWM_LEFT   = 1'b0,
      PWM_CENTER = 1'b1
   } pwm_mode_e;

   // Two's complement to offset binary is an MSB flip; unsigned codes pass straight through.
   function automatic logic [31:0] to_offset_binary(input logic [31:0] y,
                                                    input logic        signed_in,
                                                    input int unsigned out_bits);
      logic [31:0] msb_mask;
      msb_mask = 32'd1 << (out_bits - 1);
      return signed_in ? (y ^ msb_mask) : y;
   endfunction

endpackage

// File: rtl/pwm_compare.sv
// Combinational PWM level from frame counter and duty, left- or centre-aligned.
// Stateless so it can drive additional output pins from a shared counter.
module pwm_compare
   import ds_dac_pkg::*;
#(
   parameter int OUT_BITS = DEFAULT_OUT_BITS
) (
   input  logic [OUT_BITS-1:0] i_cnt,
   input  logic [OUT_BITS-1:0] i_duty,
   input  pwm_mode_e           i_mode,
   output logic                o_level
);

   localparam logic [OUT_BITS:0] PERIOD = {1'b1, {OUT_BITS{1'b0}}};

   logic [OUT_BITS:0] w_cnt_ext;
   logic [OUT_BITS:0] w_duty_ext;
   logic [OUT_BITS:0] w_lo;
   logic [OUT_BITS:0] w_hi;

   // One extra bit so lo+duty cannot wrap back into the frame.
   assign w_cnt_ext  = {1'b0, i_cnt};
   assign w_duty_ext = {1'b0, i_duty};
   assign w_lo       = (PERIOD - w_duty_ext) >> 1;
   assign w_hi       = w_lo + w_duty_ext;

   always_comb begin
      // NOTE: default first so no path leaves o_level unassigned and infers a latch.
      o_level = 1'b0;
      unique case (i_mode)
         PWM_LEFT:   o_level = (i_cnt < i_duty);
         PWM_CENTER: o_level = (w_cnt_ext >= w_lo) && (w_cnt_ext < w_hi);
      endcase
   end

endmodule

// File: rtl/ds_pwm_stage.sv
// PWM output stage behind the delta-sigma modulator: one sample per 2^OUT_BITS-clock frame.
// A pending register absorbs sample arrival; duty is only reloaded at the frame wrap.
module ds_pwm_stage
   import ds_dac_pkg::*;
#(
   parameter int OUT_BITS  = DEFAULT_OUT_BITS,
   parameter int SIGNED_IN = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                centered,
   input  logic [OUT_BITS-1:0] y,
   input  logic                y_valid,
   input  logic                clear_flags,
   output logic                pwm_out,
   output logic                sample_req,
   output logic                frame_start,
   output logic                overrun,
   output logic                underrun
);

   localparam logic [OUT_BITS-1:0] CNT_MAX      = '1;
   localparam logic [OUT_BITS-1:0] CNT_HALF     = {1'b1, {(OUT_BITS-1){1'b0}}};
   localparam logic [OUT_BITS-1:0] CNT_PRE_HALF = CNT_HALF - OUT_BITS'(1);

   logic [OUT_BITS-1:0] r_cnt;
   logic [OUT_BITS-1:0] r_duty;
   logic [OUT_BITS-1:0] r_pending;
   logic                r_pending_full;
   logic                r_pwm;
   logic                r_sample_req;
   logic                r_frame_start;
   logic                r_overrun;
   logic                r_underrun;

   logic [OUT_BITS-1:0] w_d;
   logic                w_wrap;
   logic                w_level;
   logic                w_overrun_set;
   logic                w_underrun_set;
   pwm_mode_e           w_mode;

   assign w_d    = OUT_BITS'(to_offset_binary(32'(y), 1'(SIGNED_IN != 0), OUT_BITS));
   assign w_wrap = en && (r_cnt == CNT_MAX);
   assign w_mode = pwm_mode_e'(centered);

   // A sample landing on the wrap edge is consumed by the load, so it never counts as overrun.
   assign w_overrun_set  = y_valid && !w_wrap && r_pending_full;
   assign w_underrun_set = w_wrap && !r_pending_full && !y_valid;

   pwm_compare #(
      .OUT_BITS (OUT_BITS)
   ) u_pwm_compare (
      .i_cnt   (r_cnt),
      .i_duty  (r_duty),
      .i_mode  (w_mode),
      .o_level (w_level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt         <= '0;
         r_pwm         <= 1'b0;
         r_sample_req  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register here samples pre-edge values of the others.
         r_cnt         <= en ? r_cnt + OUT_BITS'(1) : '0;
         r_pwm         <= en && w_level;
         r_sample_req  <= en && (r_cnt == CNT_PRE_HALF);
         r_frame_start <= w_wrap;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_duty         <= '0;
         r_pending      <= '0;
         r_pending_full <= 1'b0;
      end else if (w_wrap) begin
         if (r_pending_full) begin
            r_duty <= r_pending;
            if (y_valid) begin
               r_pending <= w_d;
            end else begin
               r_pending_full <= 1'b0;
            end
         end else if (y_valid) begin
            r_duty <= w_d;
         end
      end else if (y_valid) begin
         r_pending      <= w_d;
         r_pending_full <= 1'b1;
      end
   end

   // Set beats clear so an event coinciding with a software clear is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overrun  <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_overrun  <= w_overrun_set  || (r_overrun  && !clear_flags);
         r_underrun <= w_underrun_set || (r_underrun && !clear_flags);
      end
   end

   assign pwm_out     = r_pwm;
   assign sample_req  = r_sample_req;
   assign frame_start = r_frame_start;
   assign overrun     = r_overrun;
   assign underrun    = r_underrun;

endmodule

// File: tb/tb_ds_pwm_stage.sv
// Self-checking bench for ds_pwm_stage (OUT_BITS=9, signed input).
// A frame monitor measures each PWM frame and compares it to scoreboard entries.
module tb_ds_pwm_stage;

   localparam int OB     = 9;
   localparam int PERIOD = 512;

   typedef struct {
      string      name;
      logic [8:0] y;
      logic       centered;
      int         exp_high;
      int         exp_first;
      int         exp_last;
   } vec_t;

   typedef struct {
      int frame;
      int high;
      int first;
      int last;
   } sb_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          centered;
   logic [OB-1:0] y;
   logic          y_valid;
   logic          clear_flags;
   logic          pwm_out;
   logic          sample_req;
   logic          frame_start;
   logic          overrun;
   logic          underrun;

   int  n_checks = 0;
   int  n_fail   = 0;
   sb_t sb_q[$];

   bit  mon_on = 1'b0;
   bit  mon_active;
   int  mon_frame, mon_cur, mon_p, mon_gap, mon_high, mon_first, mon_last;

   vec_t vecs[6];

   ds_pwm_stage #(.OUT_BITS(OB), .SIGNED_IN(1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .centered    (centered),
      .y           (y),
      .y_valid     (y_valid),
      .clear_flags (clear_flags),
      .pwm_out     (pwm_out),
      .sample_req  (sample_req),
      .frame_start (frame_start),
      .overrun     (overrun),
      .underrun    (underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic sb_t exp_left(input int frame, input int d);
      sb_t e;
      e.frame = frame;
      e.high  = d;
      e.first = (d > 0) ? 0 : -1;
      e.last  = (d > 0) ? d - 1 : -1;
      return e;
   endfunction

   // Measures one frame: window covers cnt 0..511, seen one clock late on pwm_out.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_on) begin
            mon_gap++;
            if (mon_active) begin
               mon_p++;
               if (pwm_out === 1'b1) begin
                  if (mon_first < 0) mon_first = mon_p - 1;
                  mon_last = mon_p - 1;
                  mon_high++;
               end
               if (mon_p == PERIOD) begin
                  if (sb_q.size() > 0 && sb_q[0].frame < mon_cur) begin
                     check("sb_order", sb_q[0].frame, mon_cur);
                     void'(sb_q.pop_front());
                  end
                  if (sb_q.size() > 0 && sb_q[0].frame == mon_cur) begin
                     sb_t e;
                     e = sb_q.pop_front();
                     check($sformatf("frame%0d_high", mon_cur),  mon_high,  e.high);
                     check($sformatf("frame%0d_first", mon_cur), mon_first, e.first);
                     check($sformatf("frame%0d_last", mon_cur),  mon_last,  e.last);
                  end
                  mon_active = 1'b0;
               end
            end
            if (frame_start === 1'b1) begin
               if (mon_frame > 0) check("frame_gap", mon_gap, PERIOD);
               mon_gap    = 0;
               mon_frame++;
               mon_cur    = mon_frame;
               mon_active = 1'b1;
               mon_p      = 0;
               mon_high   = 0;
               mon_first  = -1;
               mon_last   = -1;
            end
         end
      end
   end

   // All driver tasks start and end at negedge+1.
   task automatic start_run(input logic c);
      centered   = c;
      mon_frame  = 0;
      mon_gap    = 0;
      mon_active = 1'b0;
      mon_on     = 1'b1;
      en         = 1'b1;
   endtask

   task automatic stop_run();
      en     = 1'b0;
      mon_on = 1'b0;
      check("sb_drained", sb_q.size(), 0);
      sb_q.delete();
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic pulse_y(input logic [OB-1:0] val);
      y       = val;
      y_valid = 1'b1;
      @(negedge clk);
      #1;
      y_valid = 1'b0;
   endtask

   task automatic pulse_d(input int d);
      pulse_y(OB'(d) ^ 9'h100);
   endtask

   task automatic do_clear();
      clear_flags = 1'b1;
      @(negedge clk);
      #1;
      clear_flags = 1'b0;
   endtask

   task automatic wait_req();
      bit seen = 1'b0;
      for (int i = 0; i < 700 && !seen; i++) begin
         @(negedge clk);
         if (sample_req === 1'b1) seen = 1'b1;
      end
      #1;
      check("sample_req_seen", int'(seen), 1);
   endtask

   task automatic wait_frame(input int n);
      for (int i = 0; i < 4 * PERIOD && mon_frame < n; i++) begin
         @(negedge clk);
         #1;
      end
      check($sformatf("reach_frame%0d", n), mon_frame, n);
   endtask

   initial begin
      int ones, pulses;
      int d;

      vecs[0] = '{"signed_zero",  9'h000, 1'b0, 256,  0, 255};
      vecs[1] = '{"signed_min",   9'h100, 1'b0,   0, -1,  -1};
      vecs[2] = '{"signed_max",   9'h0FF, 1'b0, 511,  0, 510};
      vecs[3] = '{"ctr_d100",     9'h164, 1'b1, 100, 206, 305};
      vecs[4] = '{"ctr_d511",     9'h0FF, 1'b1, 511,  0, 510};
      vecs[5] = '{"signed_neg1",  9'h1FF, 1'b0, 255,  0, 254};

      rst_n       = 1'b0;
      en          = 1'b0;
      centered    = 1'b0;
      y           = '0;
      y_valid     = 1'b0;
      clear_flags = 1'b0;

      // Reset state and idle with en low.
      repeat (3) @(negedge clk);
      check("rst_pwm",   int'(pwm_out),     0);
      check("rst_req",   int'(sample_req),  0);
      check("rst_fs",    int'(frame_start), 0);
      check("rst_ovr",   int'(overrun),     0);
      check("rst_udr",   int'(underrun),    0);
      #1;
      rst_n  = 1'b1;
      ones   = 0;
      pulses = 0;
      repeat (100) begin
         @(negedge clk);
         ones   += int'(pwm_out);
         pulses += int'(sample_req) + int'(frame_start);
      end
      #1;
      check("idle_pwm_high", ones,   0);
      check("idle_pulses",   pulses, 0);
      check("idle_flags",    int'(overrun) + int'(underrun), 0);

      // Table: one sample delivered mid-frame 0 shapes frame 1.
      foreach (vecs[i]) begin
         start_run(vecs[i].centered);
         wait_req();
         pulse_y(vecs[i].y);
         sb_q.push_back('{1, vecs[i].exp_high, vecs[i].exp_first, vecs[i].exp_last});
         wait_frame(2);
         stop_run();
         do_clear();
      end

      // Underrun: one sample, then the duty repeats.
      start_run(1'b0);
      wait_req();
      pulse_d(300);
      for (int f = 1; f <= 3; f++) sb_q.push_back(exp_left(f, 300));
      wait_frame(1);
      check("udr_after_load", int'(underrun), 0);
      wait_frame(2);
      check("udr_after_wrap2", int'(underrun), 1);
      do_clear();
      check("udr_cleared", int'(underrun), 0);
      wait_frame(4);
      stop_run();
      do_clear();

      // Overrun, bypass on the wrap edge, and wrap-edge sample with pending full.
      start_run(1'b0);
      wait_req();
      pulse_d(10);
      repeat (3) @(negedge clk);
      #1;
      check("ovr_before_second", int'(overrun), 0);
      pulse_d(20);
      check("ovr_set", int'(overrun), 1);
      sb_q.push_back(exp_left(1, 20));
      do_clear();
      check("ovr_cleared", int'(overrun), 0);
      wait_frame(1);
      repeat (511) @(negedge clk);
      #1;
      pulse_d(40);
      sb_q.push_back(exp_left(2, 40));
      check("bypass_frame", mon_frame, 2);
      check("bypass_no_udr", int'(underrun), 0);
      repeat (100) @(negedge clk);
      #1;
      pulse_d(70);
      repeat (410) @(negedge clk);
      #1;
      pulse_d(90);
      sb_q.push_back(exp_left(3, 70));
      sb_q.push_back(exp_left(4, 90));
      check("held_frame", mon_frame, 3);
      check("held_no_ovr", int'(overrun), 0);
      check("held_no_udr", int'(underrun), 0);
      wait_frame(5);
      check("held_then_udr", int'(underrun), 1);
      stop_run();
      do_clear();

      // Pacing: one sample per sample_req over 20 frames.
      start_run(1'b0);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         wait_req();
         d = int'($urandom_range(511, 0));
         pulse_d(d);
         sb_q.push_back(exp_left(mon_frame + 1, d));
         pulses++;
      end
      wait_frame(20);
      check("pace_samples", pulses, 20);
      check("pace_ovr", int'(overrun), 0);
      check("pace_udr", int'(underrun), 0);
      wait_frame(21);
      stop_run();
      do_clear();

      // Mid-frame reset drops pwm_out without a clock and clears duty.
      start_run(1'b0);
      wait_req();
      pulse_d(300);
      wait_frame(1);
      repeat (50) @(negedge clk);
      #1;
      check("pre_rst_pwm", int'(pwm_out), 1);
      mon_on = 1'b0;
      sb_q.delete();
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_pwm", int'(pwm_out), 0);
      check("async_rst_fs",  int'(frame_start), 0);
      en = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      start_run(1'b0);
      sb_q.push_back(exp_left(1, 0));
      wait_frame(2);
      stop_run();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
